serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: loads two WIDTH-bit operands on start, then adds one bit
// per clock LSB-first, producing sum/cout with a one-cycle done pulse.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN, which
// adds a 'sub' input (a - b computed as a + ~b + 1).
//
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold last result
//   RUN   | one full-add per cycle, WIDTH cycles total
//   DONE  | one-cycle result strobe; start here chains a new operation

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must be at least one bit wide so WIDTH=1 still elaborates.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_cnext;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_init;
    logic [WIDTH-1:0]   w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction reuses the adder: invert b and inject the +1 through carry-in.
    assign w_b_load = sub ? ~b : b;
    assign w_c_init = sub;
`else
    assign w_b_load = b;
    assign w_c_init = 1'b0;
`endif

    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cnext    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // New sum bit enters at the MSB end; written as shift/or so WIDTH=1 works.
    assign w_sum_next = (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    assign sum  = r_sum;
    assign cout = r_cout;

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= w_b_load;
            r_c   <= w_c_init;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sum <= w_sum_next;
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_cnext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_cnext;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases with literal
// expectations plus randomized traffic checked every cycle against an
// arithmetic reference model.

module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done_seen = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks when the current operation finishes and what
    // the arithmetic result must be, from acceptance time and operand values.
    int           cyc = 0;
    bit           m_valid = 0;
    bit           m_active = 0;
    int           m_end = 0;
    logic [W-1:0] m_pend_sum, m_sum;
    logic         m_pend_cout, m_cout;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_active = 0;
            m_sum    = '0;
            m_cout   = 1'b0;
            m_valid  = 1;
        end else if (m_valid) begin
            if (m_active && cyc == m_end) begin
                m_sum  = m_pend_sum;
                m_cout = m_pend_cout;
            end
            if (start && !(m_active && cyc <= m_end)) begin
`ifdef SERIAL_ADDER_SUB_EN
                if (sub) begin
                    m_pend_sum  = W'(int'(a) - int'(b));
                    m_pend_cout = (a >= b);
                end else begin
                    m_pend_sum  = W'(int'(a) + int'(b));
                    m_pend_cout = (int'(a) + int'(b)) >= (1 << W);
                end
`else
                m_pend_sum  = W'(int'(a) + int'(b));
                m_pend_cout = (int'(a) + int'(b)) >= (1 << W);
`endif
                m_active = 1;
                m_end    = cyc + W;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 33'(busy), 33'(m_active && cyc < m_end));
            chk("done", 33'(done), 33'(m_active && cyc == m_end));
            if (m_active && cyc == m_end) n_done_seen++;
            if (!(m_active && cyc < m_end)) begin
                chk("sum_model", 33'(sum), 33'(m_sum));
                chk("cout_model", 33'(cout), 33'(m_cout));
            end
        end
    end

    // Drives one operation and checks literal results and latency. If
    // 'immediate' is set, operands are applied at the current negedge
    // (used to chain during DONE). inj>=0 pulses start with 0xFF/0xFF
    // at that RUN cycle index.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] es, input logic ec,
                          input string nm, input bit immediate, input int inj);
        int  busy_cnt;
        bit  got;
        busy_cnt = 0;
        got = 0;
        if (!immediate) @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == inj) begin
                start = 1'b1;
                a = '1;
                b = '1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                got = 1;
                chk({nm, "_latency"}, 33'(i), 33'(W));
                chk({nm, "_sum"}, 33'(sum), 33'(es));
                chk({nm, "_cout"}, 33'(cout), 33'(ec));
                chk({nm, "_busy_cycles"}, 33'(busy_cnt), 33'(W));
            end
        end
        if (!got) chk({nm, "_timeout"}, 33'(0), 33'(1));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return '0;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int dcnt;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", 33'(busy), 33'(0));
        chk("reset_done", 33'(done), 33'(0));
        chk("reset_sum", 33'(sum), 33'(0));
        chk("reset_cout", 33'(cout), 33'(0));
        rst_n = 1'b1;

        run_op(8'h5A, 8'h33, 8'h8D, 1'b0, "add_5a_33", 0, -1);
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01", 0, -1);
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff", 0, -1);
        @(negedge clk);
        chk("hold_sum", 33'(sum), 33'(8'hFE));
        chk("hold_cout", 33'(cout), 33'(1));

        run_op(8'h10, 8'h20, 8'h30, 1'b0, "ignore_start", 0, 2);
        start = 1'b0;

        // Back-to-back: start asserted in the DONE cycle.
        run_op(8'h07, 8'h09, 8'h10, 1'b0, "chain_first", 0, -1);
        run_op(8'h01, 8'h02, 8'h03, 1'b0, "chain_second", 1, -1);
        start = 1'b0;

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_busy", 33'(busy), 33'(0));
        chk("midrun_rst_done", 33'(done), 33'(0));
        chk("midrun_rst_sum", 33'(sum), 33'(0));
        chk("midrun_rst_cout", 33'(cout), 33'(0));
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrun_rst_no_done", 33'(dcnt), 33'(0));

        // Start coincident with reset is dropped.
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'h44;
        b = 8'h44;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_busy", 33'(busy), 33'(0));

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(8'h10, 8'h01, 8'h0F, 1'b1, "sub_10_01", 0, -1);
        run_op(8'h00, 8'h01, 8'hFF, 1'b0, "sub_00_01", 0, -1);
        sub = 1'b0;
`endif

        // Randomized traffic: random start, operands, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 3) == 0);
            a = pick();
            b = pick();
`ifdef SERIAL_ADDER_SUB_EN
            sub = $urandom_range(0, 1) != 0;
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("random_done_count_nonzero", 33'(n_done_seen > 50), 33'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
